// File: rtl/seven_seg_scanner_if.sv
// Digit-scanner bus: display value and controls toward the scanner, and the
// decoder nibble with anode enables coming back out.
interface seven_seg_scanner_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] value_in;
    logic                load;
    logic                blank_lz;
    logic [3:0]          digit_data;
    logic [IDX_W-1:0]    digit_idx;
    logic [DIGITS-1:0]   anodes;
    logic                digit_blank;

    modport master (
        output value_in, load, blank_lz,
        input  digit_data, digit_idx, anodes, digit_blank
    );

    modport slave (
        input  value_in, load, blank_lz,
        output digit_data, digit_idx, anodes, digit_blank
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex digit scanner feeding a seven-segment decoder, with
// active-low common-anode enables and optional leading-zero blanking.
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scanner_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic [4*DIGITS-1:0] value_reg;
    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx_reg;

    logic [DIGITS-1:0]   lz_zero;
    logic                zero_acc;
    logic [3:0]          cur_nibble;
    logic                blank_now;
    logic                div_last;
    logic                idx_last;

    // lz_zero[i] is set when nibbles DIGITS-1 down to i are all zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lz_zero  = '0;
        zero_acc = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc   = zero_acc & (value_reg[4*i +: 4] == 4'h0);
            lz_zero[i] = zero_acc;
        end
    end

    always_comb begin
        cur_nibble = value_reg[{idx_reg, 2'b00} +: 4];
        blank_now  = bus.blank_lz && (idx_reg != '0) && lz_zero[idx_reg];
        div_last   = (div_cnt == DIV_W'(REFRESH_DIV - 1));
        idx_last   = (idx_reg == IDX_W'(DIGITS - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: value_reg is a plain register, not a memory, so it is reset to show a clean 0 after reset.
            value_reg       <= '0;
            div_cnt         <= '0;
            idx_reg         <= '0;
            bus.digit_data  <= '0;
            bus.digit_idx   <= '0;
            bus.anodes      <= '1;
            bus.digit_blank <= 1'b1;
        end else begin
            if (bus.load) begin
                value_reg <= bus.value_in;
            end

            if (div_last) begin
                div_cnt <= '0;
                idx_reg <= idx_last ? '0 : idx_reg + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Outputs follow idx_reg/value_reg by one cycle; only one anode can go low.
            bus.digit_data  <= cur_nibble;
            bus.digit_idx   <= idx_reg;
            bus.anodes      <= blank_now ? '1 : ~(DIGITS'(1) << idx_reg);
            bus.digit_blank <= blank_now;
        end
    end
endmodule
